// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: word width, default
// sizing and the arbiter state encoding.
package definitions;

  localparam int DATASIZE     = 8;
  localparam int NREQ_DEF     = 4;
  localparam int MAXBURST_DEF = 8;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker. Searches the candidate set (req minus
// excl) starting one position after `last`, wrapping modulo NREQ.
module rr_pick import definitions::*; #(
  parameter int NREQ = NREQ_DEF,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  input  logic [NREQ-1:0] excl,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            found
);

  logic [NREQ-1:0] cand;
  logic [IW-1:0]   pos;

  assign cand = req & ~excl;

  // First candidate at or after last+1 wins; later hits are ignored.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = IW'((int'(last) + k) % NREQ);
      if (!found && cand[pos]) begin
        found       = 1'b1;
        win_idx     = pos;
        win_oh[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for the FIFO write port. One producer owns the
// port per burst; beats are written whenever the owner has data and the
// FIFO is not full. Bursts end on req_last, on MAXBURST beats, or when the
// owner drops req, and the next owner is chosen in that same cycle.
module fifo_write_arbiter #(
  parameter int NREQ     = definitions::NREQ_DEF,
  parameter int MAXBURST = definitions::MAXBURST_DEF,
  parameter int DATASIZE = definitions::DATASIZE,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                           wclk,
  input  logic                           wrst_n,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ-1:0][DATASIZE-1:0]  req_data,
  input  logic [NREQ-1:0]                req_last,
  output logic [NREQ-1:0]                gnt,
  output logic [NREQ-1:0]                accept,
  output logic                           wen,
  output logic [DATASIZE-1:0]            wdata,
  input  logic                           wfull,
  output logic [IW-1:0]                  owner,
  output logic                           busy
);

  import definitions::*;

  localparam int CW = $clog2(MAXBURST) + 1;

  arb_state_t      state_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [IW-1:0]   owner_reg;
  logic [IW-1:0]   last_reg;
  logic [CW-1:0]   count_reg;

  logic            owner_req;
  logic            beat;
  logic            burst_done;
  logic [CW-1:0]   count_next;
  logic [NREQ-1:0] others;
  logic [NREQ-1:0] excl;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;

  assign busy  = (state_reg == ARB_BURST);
  assign gnt   = gnt_reg;
  assign owner = owner_reg;

  // Beat path: the owner's word goes straight to the FIFO when it is not full.
  assign owner_req  = req[owner_reg];
  assign beat       = busy & owner_req & ~wfull;
  assign wen        = beat;
  assign wdata      = busy ? req_data[owner_reg] : '0;
  assign accept     = NREQ'(beat) << owner_reg;
  assign count_next = count_reg + CW'(1);

  assign burst_done = busy & (~owner_req |
                      (beat & (req_last[owner_reg] | (count_next == CW'(MAXBURST)))));

  // The departing owner is excluded unless nobody else wants the port.
  // gnt_reg is zero when idle, so no exclusion applies there.
  assign others = req & ~gnt_reg;
  assign excl   = (|others) ? gnt_reg : '0;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .last    (last_reg),
    .excl    (excl),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .found   (pick_found)
  );

  // Arbiter FSM: grant, burst counting and same-cycle re-arbitration.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg <= ARB_IDLE;
      gnt_reg   <= '0;
      owner_reg <= '0;
      last_reg  <= IW'(NREQ - 1);
      count_reg <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (pick_found) begin
            state_reg <= ARB_BURST;
            gnt_reg   <= pick_oh;
            owner_reg <= pick_idx;
            last_reg  <= pick_idx;
            count_reg <= '0;
          end
        end
        ARB_BURST: begin
          if (burst_done) begin
            count_reg <= '0;
            if (pick_found) begin
              gnt_reg   <= pick_oh;
              owner_reg <= pick_idx;
              last_reg  <= pick_idx;
            end else begin
              state_reg <= ARB_IDLE;
              gnt_reg   <= '0;
            end
          end else if (beat) begin
            count_reg <= count_next;
          end
        end
        default: begin
          state_reg <= ARB_IDLE;
          gnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level arbiter model.
module tb_fifo_write_arbiter;
  import definitions::*;

  localparam int N  = 4;
  localparam int MB = 8;
  localparam int DW = DATASIZE;
  localparam int IW = $clog2(N);

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [N-1:0]          req;
  logic [N-1:0][DW-1:0]  req_data;
  logic [N-1:0]          req_last;
  logic [N-1:0]          gnt;
  logic [N-1:0]          accept;
  logic                  wen;
  logic [DW-1:0]         wdata;
  logic                  wfull;
  logic [IW-1:0]         owner;
  logic                  busy;

  always #5 wclk = ~wclk;

  fifo_write_arbiter #(.NREQ(N), .MAXBURST(MB), .DATASIZE(DW)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .gnt      (gnt),
    .accept   (accept),
    .wen      (wen),
    .wdata    (wdata),
    .wfull    (wfull),
    .owner    (owner),
    .busy     (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model of the arbiter: who owns the port, beats so far, last winner.
  bit m_active;
  int m_owner;
  int m_last;
  int m_beats;

  logic          obs_wen;
  logic [DW-1:0] obs_wdata;
  logic [N-1:0]  obs_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] cand, input int from);
    logic [IW-1:0] ix;
    for (int k = 1; k <= N; k++) begin
      ix = IW'((from + k) % N);
      if (cand[ix]) return int'(ix);
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_owner  = 0;
    m_last   = N - 1;
    m_beats  = 0;
  endtask

  task automatic model_grant(input int w);
    m_active = 1;
    m_owner  = w;
    m_last   = w;
    m_beats  = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic step(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                      input logic [N-1:0] l, input logic f);
    logic [N-1:0]  eg;
    logic [N-1:0]  ea;
    logic [N-1:0]  cand;
    logic [DW-1:0] ed;
    logic [IW-1:0] ox;
    logic          bt;
    logic          done;
    int            w;
    @(negedge wclk);
    req      = r;
    req_data = d;
    req_last = l;
    wfull    = f;
    #1;
    ox = IW'(m_owner);
    bt = m_active && r[ox] && !f;
    eg = m_active ? (N'(1) << m_owner) : '0;
    ed = m_active ? d[m_owner*DW +: DW] : '0;
    ea = bt ? eg : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("wen", 32'(wen), 32'(bt));
    chk("wdata", 32'(wdata), 32'(ed));
    chk("accept", 32'(accept), 32'(ea));
    chk("busy", 32'(busy), 32'(m_active));
    if (m_active) chk("owner", 32'(owner), 32'(m_owner));
    chk("wen_while_full", 32'(wen & wfull), 32'(0));
    obs_wen   = wen;
    obs_wdata = wdata;
    obs_gnt   = gnt;
    if (!m_active) begin
      w = rr_next(r, m_last);
      if (w >= 0) model_grant(w);
    end else begin
      done = !r[ox];
      if (bt) begin
        m_beats++;
        if (l[ox] || m_beats == MB) done = 1'b1;
      end
      if (done) begin
        cand = r & ~eg;
        if (cand == '0) cand = r;
        w = rr_next(cand, m_last);
        if (w >= 0) model_grant(w);
        else m_active = 0;
      end
    end
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    req    = '0;
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int writes;
    int w;
    int rd;
    int cyc;
    logic [DW-1:0] q[$];
    logic [DW-1:0] tmp;

    req = '0; req_data = '0; req_last = '0; wfull = 1'b0; wrst_n = 1'b0;
    model_reset();

    // Reset state, with all requests asserted to show they are ignored.
    repeat (2) @(negedge wclk);
    req = '1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_accept", 32'(accept), 32'(0));
    chk("rst_wen", 32'(wen), 32'(0));
    chk("rst_wdata", 32'(wdata), 32'(0));
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    do_reset();

    // Single producer 2, three words A1..A3 with last on A3.
    step(4'b0100, 32'h00A1_0000, 4'b0000, 1'b0);
    chk("sp_gnt_idle", 32'(obs_gnt), 32'(0));
    step(4'b0100, 32'h00A1_0000, 4'b0000, 1'b0);
    chk("sp_gnt", 32'(obs_gnt), 32'h4);
    chk("sp_w1", 32'({obs_wen, obs_wdata}), 32'h1A1);
    step(4'b0100, 32'h00A2_0000, 4'b0000, 1'b0);
    chk("sp_w2", 32'({obs_wen, obs_wdata}), 32'h1A2);
    step(4'b0100, 32'h00A3_0000, 4'b0100, 1'b0);
    chk("sp_w3", 32'({obs_wen, obs_wdata}), 32'h1A3);
    step(4'b0000, 32'h0, 4'b0000, 1'b0);
    chk("sp_no_write", 32'(obs_wen), 32'(0));
    step(4'b0000, 32'h0, 4'b0000, 1'b0);
    chk("sp_idle", 32'(obs_gnt), 32'(0));

    // All four requesting: 8-beat bursts rotating 0,1,2,3,0 with no bubbles.
    do_reset();
    writes = 0;
    for (int c = 0; c <= 33; c++) begin
      step(4'b1111, $urandom, 4'b0000, 1'b0);
      if (c <= 32 && obs_wen) writes++;
      if (c % 8 == 1) chk("rr_gnt", 32'(obs_gnt), 32'(1) << (((c - 1) / 8) % 4));
    end
    chk("rr_writes_in_33", 32'(writes), 32'd32);

    // wfull held for 5 cycles after 3 beats of producer 1.
    do_reset();
    writes = 0;
    for (int c = 0; c <= 14; c++) begin
      step(4'b0010, $urandom, 4'b0000, (c >= 4 && c <= 8));
      if (c >= 4 && c <= 8) begin
        chk("full_hold_gnt", 32'(obs_gnt), 32'h2);
        chk("full_no_wen", 32'(obs_wen), 32'(0));
      end
      if (c <= 13 && obs_wen) writes++;
    end
    chk("full_beats", 32'(writes), 32'd8);

    // Owner 0 drops req after 2 beats; producer 3 takes over without a gap.
    do_reset();
    writes = 0;
    step(4'b0001, $urandom, 4'b0000, 1'b0);
    step(4'b1001, $urandom, 4'b0000, 1'b0);
    if (obs_wen) writes++;
    step(4'b1001, $urandom, 4'b0000, 1'b0);
    if (obs_wen) writes++;
    chk("drop_writes", 32'(writes), 32'd2);
    step(4'b1000, $urandom, 4'b0000, 1'b0);
    chk("drop_gnt_hold", 32'(obs_gnt), 32'h1);
    chk("drop_no_wen", 32'(obs_wen), 32'(0));
    step(4'b1000, $urandom, 4'b0000, 1'b0);
    chk("drop_next_owner", 32'(obs_gnt), 32'h8);

    // Asynchronous reset between clock edges mid-burst.
    do_reset();
    step(4'b1000, $urandom, 4'b0000, 1'b0);
    step(4'b1000, $urandom, 4'b0000, 1'b0);
    step(4'b1000, $urandom, 4'b0000, 1'b0);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'(0));
    chk("arst_wen", 32'(wen), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    model_reset();
    req = '0;
    @(negedge wclk);
    wrst_n = 1'b1;
    step(4'b1001, $urandom, 4'b0000, 1'b0);
    step(4'b1001, $urandom, 4'b0000, 1'b0);
    chk("arst_first_gnt", 32'(obs_gnt), 32'h1);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step(N'($urandom), $urandom, N'($urandom) & N'($urandom), ($urandom % 5 == 0));
    end

    // 1024-word stream from producer 0 into a 16-deep FIFO read every third cycle.
    do_reset();
    q.delete();
    w = 0; rd = 0; cyc = 0;
    while (rd < 1024 && cyc < 8000) begin
      step((w < 1024) ? 4'b0001 : 4'b0000, 32'(w & 255), (w % 8 == 7) ? 4'b0001 : 4'b0000,
           (q.size() >= 16));
      if (obs_wen) begin
        q.push_back(obs_wdata);
        w++;
      end
      if (cyc % 3 == 2 && q.size() > 0) begin
        tmp = q.pop_front();
        chk("stream_order", 32'(tmp), 32'(rd & 255));
        rd++;
      end
      cyc++;
    end
    chk("stream_words_read", 32'(rd), 32'd1024);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter sharing the asynchronous FIFO's single write port among `NREQ` producers in the write clock domain. Each grant is a burst of up to `MAXBURST` words. The block drives `wen`/`wdata` directly into the FIFO's write side and stalls on `wfull` without dropping data. It sits between the producer blocks and `asynchronous_FIFO`, replacing direct bench/producer drive of `wen`.

## Interface
Parameters:
- `NREQ`, 4: number of producers; 2..8.
- `MAXBURST`, 8: maximum beats per grant; at least 1.
- `DATASIZE`, package value: word width, equal to the FIFO's `DATASIZE`.

Ports:
- `wclk`  in  1: write-domain clock. The block uses one clock only.
- `wrst_n`  in  1: reset, asynchronous and active-low.
- `req`  in  NREQ: producer i has a word ready on `req_data[i]`.
- `req_data`  in  NREQ x DATASIZE: per-producer write data.
- `req_last`  in  NREQ: the current word of producer i is the last of its packet.
- `gnt`  out  NREQ: one-hot registered grant; all zero when idle.
- `accept`  out  NREQ: word on `req_data[i]` written this cycle. Producer advances on `accept`.
- `wen`  out  1: FIFO write enable.
- `wdata`  out  DATASIZE: FIFO write data.
- `wfull`  in  1: FIFO full flag, synchronous to `wclk`.
- `owner`  out  clog2(NREQ): index of the current grantee; valid when `busy`.
- `busy`  out  1: the FSM is in ARB_BURST.

## Operation
- State machine:
  - ARB_IDLE: `gnt` is 0. If any `req` is set, pick a winner and go to ARB_BURST with `gnt` one-hot on the winner.
  - ARB_BURST: a beat is written when `req[owner] && !wfull`.
- Winner selection is round-robin. Search starts at `last+1` mod NREQ. `last` updates to the winner at each grant.
- Beat logic is combinational within ARB_BURST:
  - `wen = req[owner] & ~wfull`
  - `wdata = req_data[owner]`
  - `accept = wen << owner`
- Beat counter: clog2(MAXBURST)+1 bits. Cleared on each grant; increments per beat.
- A burst ends on any of:
  - a beat with `req_last[owner]`;
  - a beat that makes count equal `MAXBURST`;
  - `req[owner]` low in ARB_BURST, which ends the burst without a beat.
- At burst end, re-arbitrate in the same cycle. The candidate set excludes the departing owner unless it is the only requester. If there is any candidate, go straight to ARB_BURST with the new owner; otherwise go to ARB_IDLE.
- `wfull` high in ARB_BURST: no beat, the counter holds and the grant holds indefinitely. There is no timeout.
- Non-owner `req` bits are ignored mid-burst and `accept` stays 0 for them.
- `wen` is never asserted while `wfull` is high. This is an invariant.

## Timing
- Reset values:
  - `gnt` = 0, `accept` = 0, `wen` = 0, `wdata` = 0 (ARB_IDLE forces the mux to 0), `owner` = 0, `busy` = 0;
  - state ARB_IDLE, `last` = NREQ-1 (producer 0 has top priority), counter = 0.
- Reset mid-burst: all outputs return to reset values asynchronously. A partial packet is abandoned; producers must restart.
- Grant latency: `req` rising in ARB_IDLE at edge N gives `gnt` at N+1. The first beat is possible in the cycle after N+1 if `wfull` is low.
- Back-to-back bursts: zero idle cycles between owners when the other producer's `req` is pending at burst end.
- Throughput: one word per cycle while the owner holds `req` and `wfull` is low.
- `wfull` reaching the FIFO carries the FIFO's own synchronizer delay. The arbiter adds no extra pessimism; the FIFO flag is conservative.

## Structure
- Package `definitions` holds:
  - `DATASIZE`;
  - `typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t`;
  - default `NREQ` and `MAXBURST` constants.
- Sub-module `rr_pick`: purely combinational. Inputs are the request vector, `last` and an exclude mask; outputs are a one-hot winner and an index. It is instantiated once.
- The top level is `fifo_write_arbiter` and contains the FSM, counter, `last` register and data mux. Its outputs connect by name to `asynchronous_FIFO` (`wen`, `wdata`, `wfull`, `wclk`, `wrst_n`).

## Test plan
- Single producer: `req[2]` high with 3 words 0xA1..0xA3, `req_last` on the third.
  - `gnt` = 0100 one cycle after `req`; then 3 consecutive `wen` carrying A1, A2, A3; then ARB_IDLE.
- All four requesting continuously, `MAXBURST` = 8, no `req_last`.
  - Grants cycle 0, 1, 2, 3, 0 with 8 beats each, no bubble between owners, 32 FIFO writes in 33 cycles.
- `wfull` forced high for 5 cycles mid-burst of producer 1 after 3 beats.
  - `wen` and `accept` are 0 for exactly 5 cycles, the grant holds, and beats 4..8 resume afterwards.
- Owner drops `req` after 2 beats while producer 3 requests.
  - Burst ends with 2 writes and `gnt` moves to 3 next cycle without an idle cycle.
- `wrst_n` asserted low asynchronously mid-burst, between clock edges.
  - `gnt`/`wen`/`busy` go 0 immediately. After release, a `req` from producers 0 and 3 grants producer 0 first.
- 1024-word stream from producer 0 into the FIFO with a slow read side.
  - No write while `wfull` is high and all 1024 words are read back in order.
